// File: rtl/host_rd_cred_sched.sv
// Credit-based round-robin scheduler for host read requests from N_DESTS destinations.
// A request is granted only when its whole beat count fits in that destination's credits.
module host_rd_cred_sched #(
  parameter int unsigned N_DESTS    = 4,
  parameter int unsigned CRED_BEATS = 32,
  parameter int unsigned LEN_BITS   = 28,
  parameter int unsigned VADDR_BITS = 48,
  localparam int unsigned CW = $clog2(CRED_BEATS + 1),
  localparam int unsigned BW = LEN_BITS - 5,
  localparam int unsigned DW = (N_DESTS > 1) ? $clog2(N_DESTS) : 1
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [N_DESTS-1:0]             s_req_valid,
  output logic [N_DESTS-1:0]             s_req_ready,
  input  logic [N_DESTS*VADDR_BITS-1:0]  s_req_vaddr,
  input  logic [N_DESTS*LEN_BITS-1:0]    s_req_len,
  output logic                           m_req_valid,
  input  logic                           m_req_ready,
  output logic [VADDR_BITS-1:0]          m_req_vaddr,
  output logic [LEN_BITS-1:0]            m_req_len,
  output logic                           m_mux_valid,
  input  logic                           m_mux_ready,
  output logic [DW-1:0]                  m_mux_dest,
  output logic [BW-1:0]                  m_mux_beats,
  input  logic [N_DESTS-1:0]             xfer,
  output logic [N_DESTS*CW-1:0]          cred,
  output logic                           err
);

  localparam int unsigned CMPW = (BW > CW) ? BW : CW;

  typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cred [N_DESTS];
  logic [CW-1:0]         w_cred_nxt [N_DESTS];
  logic [BW-1:0]         w_beats [N_DESTS];
  logic [VADDR_BITS-1:0] w_vaddr [N_DESTS];
  logic [LEN_BITS-1:0]   w_len [N_DESTS];
  logic [N_DESTS-1:0]    w_cand, w_over, w_ovf;
  logic [DW-1:0]         r_ptr, w_win, w_lo, w_hi, w_ptr_nxt;
  logic                  w_any, w_hi_vld, w_grant, w_issue;
  logic                  r_req_valid, r_mux_valid, r_err;
  logic [VADDR_BITS-1:0] r_vaddr;
  logic [LEN_BITS-1:0]   r_len;
  logic [DW-1:0]         r_dest;
  logic [BW-1:0]         r_beats;

  // Per-destination beat count, candidacy and credit next-state
  for (genvar g = 0; g < N_DESTS; g++) begin : g_dest
    logic [CW:0]   w_sum;
    logic [CW-1:0] w_sat;
    logic [CW-1:0] w_debit;

    assign w_vaddr[g] = s_req_vaddr[g*VADDR_BITS +: VADDR_BITS];
    assign w_len[g]   = s_req_len[g*LEN_BITS +: LEN_BITS];
    assign w_beats[g] = BW'(w_len[g][LEN_BITS-1:6]) + BW'(|w_len[g][5:0]);
    assign w_over[g]  = CMPW'(w_beats[g]) > CMPW'(CRED_BEATS);
    // Oversize requests compete so they can be drained and flagged
    assign w_cand[g]  = s_req_valid[g] &
                        (w_over[g] | (CMPW'(w_beats[g]) <= CMPW'(r_cred[g])));

    assign w_sum      = {1'b0, r_cred[g]} + (CW+1)'(xfer[g]);
    assign w_ovf[g]   = w_sum > (CW+1)'(CRED_BEATS);
    assign w_sat      = w_ovf[g] ? CW'(CRED_BEATS) : w_sum[CW-1:0];
    assign w_debit    = (w_issue && (w_win == DW'(g))) ? CW'(w_beats[g]) : '0;
    assign w_cred_nxt[g] = w_sat - w_debit;

    assign cred[g*CW +: CW] = r_cred[g];
  end

  // Round-robin pick: lowest candidate at/after the pointer, else lowest overall
  always_comb begin
    w_any    = 1'b0;
    w_hi_vld = 1'b0;
    w_lo     = '0;
    w_hi     = '0;
    for (int i = N_DESTS - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_any = 1'b1;
        w_lo  = DW'(i);
        if (DW'(i) >= r_ptr) begin
          w_hi_vld = 1'b1;
          w_hi     = DW'(i);
        end
      end
    end
    w_win     = w_hi_vld ? w_hi : w_lo;
    w_ptr_nxt = (w_win == DW'(N_DESTS - 1)) ? '0 : w_win + 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    s_req_ready = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_grant            = 1'b1;
          s_req_ready[w_win] = 1'b1;
          if (!w_over[w_win]) w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if ((!r_req_valid || m_req_ready) && (!r_mux_valid || m_mux_ready))
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_issue = w_grant & ~w_over[w_win];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_req_valid <= 1'b0;
      r_mux_valid <= 1'b0;
      r_vaddr     <= '0;
      r_len       <= '0;
      r_dest      <= '0;
      r_beats     <= '0;
      r_ptr       <= '0;
      r_err       <= 1'b0;
      for (int i = 0; i < N_DESTS; i++) r_cred[i] <= CW'(CRED_BEATS);
    end else begin
      if (w_issue) begin
        r_req_valid <= 1'b1;
        r_mux_valid <= 1'b1;
        r_vaddr     <= w_vaddr[w_win];
        r_len       <= w_len[w_win];
        r_dest      <= w_win;
        r_beats     <= w_beats[w_win];
      end else begin
        if (r_req_valid && m_req_ready) r_req_valid <= 1'b0;
        if (r_mux_valid && m_mux_ready) r_mux_valid <= 1'b0;
      end
      if (w_grant) r_ptr <= w_ptr_nxt;
      if ((w_grant && w_over[w_win]) || (|w_ovf)) r_err <= 1'b1;
      for (int i = 0; i < N_DESTS; i++) r_cred[i] <= w_cred_nxt[i];
    end
  end

  assign m_req_valid = r_req_valid;
  assign m_req_vaddr = r_vaddr;
  assign m_req_len   = r_len;
  assign m_mux_valid = r_mux_valid;
  assign m_mux_dest  = r_dest;
  assign m_mux_beats = r_beats;
  assign err         = r_err;

endmodule

// File: tb/tb_host_rd_cred_sched.sv
// Bench for host_rd_cred_sched: directed scenarios then random traffic, all checked
// against a transaction-level credit/round-robin model.
module tb_host_rd_cred_sched;

  localparam int unsigned N  = 3;
  localparam int unsigned CB = 32;
  localparam int unsigned LB = 28;
  localparam int unsigned VB = 48;
  localparam int unsigned CW = $clog2(CB + 1);
  localparam int unsigned BW = LB - 5;
  localparam int unsigned DW = 2;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [N-1:0]    s_req_valid, s_req_ready, xfer;
  logic [N*VB-1:0] s_req_vaddr;
  logic [N*LB-1:0] s_req_len;
  logic            m_req_valid, m_req_ready, m_mux_valid, m_mux_ready;
  logic [VB-1:0]   m_req_vaddr;
  logic [LB-1:0]   m_req_len;
  logic [DW-1:0]   m_mux_dest;
  logic [BW-1:0]   m_mux_beats;
  logic [N*CW-1:0] cred;
  logic            err;

  host_rd_cred_sched #(.N_DESTS(N), .CRED_BEATS(CB), .LEN_BITS(LB), .VADDR_BITS(VB)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_req_vaddr(s_req_vaddr), .s_req_len(s_req_len),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_req_vaddr(m_req_vaddr), .m_req_len(m_req_len),
    .m_mux_valid(m_mux_valid), .m_mux_ready(m_mux_ready),
    .m_mux_dest(m_mux_dest), .m_mux_beats(m_mux_beats),
    .xfer(xfer), .cred(cred), .err(err)
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: credits, pointer, sticky error, one outstanding issued read
  int            m_cred [N];
  int            m_ptr;
  bit            m_err, m_busy, m_rp, m_mp;
  logic [VB-1:0] m_vaddr;
  int            m_len, m_dest, m_beats;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int beats_of(input int len);
    return (len + 63) / 64;
  endfunction

  function automatic int cred_of(input int d);
    return int'(cred[d*CW +: CW]);
  endfunction

  task automatic set_req(input int d, input bit v, input logic [VB-1:0] a, input int len);
    s_req_valid[d]          = v;
    s_req_vaddr[d*VB +: VB] = a;
    s_req_len[d*LB +: LB]   = LB'(len);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cred[i] = CB;
    m_ptr = 0; m_err = 0; m_busy = 0; m_rp = 0; m_mp = 0;
    m_vaddr = '0; m_len = 0; m_dest = 0; m_beats = 0;
  endtask

  // One clock: check every output against the model, then advance the model past the edge
  task automatic step(output int win);
    logic [N-1:0] er;
    int           deb [N];
    int           b, c;
    #1;
    win = -1;
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        automatic int d = (m_ptr + k) % N;
        b = beats_of(int'(s_req_len[d*LB +: LB]));
        if (win < 0 && s_req_valid[d] && (b > CB || b <= m_cred[d])) win = d;
      end
    end
    er = '0;
    if (win >= 0) er[win] = 1'b1;
    chk("s_req_ready", 64'(s_req_ready), 64'(er));
    chk("m_req_valid", 64'(m_req_valid), 64'(m_rp));
    chk("m_mux_valid", 64'(m_mux_valid), 64'(m_mp));
    chk("m_req_vaddr", 64'(m_req_vaddr), 64'(m_vaddr));
    chk("m_req_len",   64'(m_req_len),   64'(m_len));
    chk("m_mux_dest",  64'(m_mux_dest),  64'(m_dest));
    chk("m_mux_beats", 64'(m_mux_beats), 64'(m_beats));
    for (int i = 0; i < N; i++) chk("cred", 64'(cred_of(i)), 64'(m_cred[i]));
    chk("err", 64'(err), 64'(m_err));

    for (int i = 0; i < N; i++) deb[i] = 0;
    if (m_busy) begin
      if (m_rp && m_req_ready) m_rp = 0;
      if (m_mp && m_mux_ready) m_mp = 0;
      if (!m_rp && !m_mp) m_busy = 0;
    end else if (win >= 0) begin
      b = beats_of(int'(s_req_len[win*LB +: LB]));
      m_ptr = (win + 1) % N;
      if (b > CB) m_err = 1;
      else begin
        deb[win] = b;
        m_vaddr  = s_req_vaddr[win*VB +: VB];
        m_len    = int'(s_req_len[win*LB +: LB]);
        m_dest   = win;
        m_beats  = b;
        m_busy = 1; m_rp = 1; m_mp = 1;
      end
    end
    for (int i = 0; i < N; i++) begin
      c = m_cred[i] + int'(xfer[i]);
      if (c > CB) begin m_err = 1; c = CB; end
      m_cred[i] = c - deb[i];
    end
    @(negedge aclk);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    s_req_valid = '0; s_req_vaddr = '0; s_req_len = '0; xfer = '0;
    m_req_ready = 1'b1; m_mux_ready = 1'b1;
    model_reset();
    #1;
    chk("rst_m_req_valid", 64'(m_req_valid), 64'd0);
    chk("rst_m_mux_valid", 64'(m_mux_valid), 64'd0);
    chk("rst_s_req_ready", 64'(s_req_ready), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_outs", 64'({m_req_vaddr, m_req_len != '0, m_mux_dest, m_mux_beats}), 64'd0);
    for (int i = 0; i < N; i++) chk("rst_cred", 64'(cred_of(i)), 64'(CB));
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  bit            cur_v [N];
  logic [VB-1:0] cur_a [N];
  int            cur_l [N];

  initial begin
    int w;
    s_req_valid = '0; s_req_vaddr = '0; s_req_len = '0; xfer = '0;
    m_req_ready = 1'b1; m_mux_ready = 1'b1;
    @(negedge aclk);
    do_reset();

    // Oversize dropped with error, then a full-credit read, then credit return
    set_req(0, 1, 48'h1000, 4096);
    step(w);
    set_req(0, 0, 48'h0, 0);
    step(w);
    chk("over_err", 64'(err), 64'd1);
    chk("over_no_issue", 64'({m_req_valid, m_mux_valid}), 64'd0);
    set_req(0, 1, 48'hABCD_0000, 2048);
    step(w);
    set_req(0, 0, 48'h0, 0);
    step(w);
    step(w);
    chk("full_debit", 64'(cred_of(0)), 64'd0);
    xfer = 3'b001;
    for (int i = 0; i < 32; i++) step(w);
    xfer = '0;
    chk("cred_restored", 64'(cred_of(0)), 64'(CB));
    step(w);

    // Round-robin over three always-valid destinations
    do_reset();
    for (int d = 0; d < N; d++) set_req(d, 1, 48'(32'h100 * (d + 1)), 64);
    for (int j = 0; j < 12; j++) begin
      #1;
      chk("rr_ready", 64'(s_req_ready), (j % 2 == 0) ? 64'(1 << ((j / 2) % 3)) : 64'd0);
      if (j % 2 == 1) begin
        chk("rr_dest", 64'(m_mux_dest), 64'((j / 2) % 3));
        chk("rr_beats", 64'(m_mux_beats), 64'd1);
      end
      step(w);
    end
    s_req_valid = '0;
    step(w);

    // Credit-starved destination is skipped until one credit returns
    do_reset();
    set_req(1, 1, 48'h2000, 29 * 64);
    step(w);
    set_req(1, 0, 48'h0, 0);
    step(w);
    set_req(1, 1, 48'h3000, 256);
    set_req(2, 1, 48'h4000, 64);
    #1;
    chk("starve_pick2", 64'(s_req_ready), 64'b100);
    step(w);
    set_req(2, 0, 48'h0, 0);
    xfer = 3'b010;
    step(w);
    xfer = '0;
    #1;
    chk("starve_pick1", 64'(s_req_ready), 64'b010);
    step(w);
    set_req(1, 0, 48'h0, 0);
    step(w);

    // Host request channel stalls while routing channel completes
    do_reset();
    set_req(0, 1, 48'h5555_0040, 128);
    step(w);
    set_req(0, 0, 48'h0, 0);
    set_req(1, 1, 48'h6000, 64);
    m_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) step(w);
    chk("stall_hold_valid", 64'({m_req_valid, m_mux_valid}), 64'b10);
    chk("stall_hold_addr", 64'(m_req_vaddr), 64'h5555_0040);
    m_req_ready = 1'b1;
    step(w);
    #1;
    chk("stall_back_idle", 64'(s_req_ready), 64'b010);
    step(w);
    set_req(1, 0, 48'h0, 0);
    step(w);

    // Credit overflow saturates; debit and return in one cycle net out
    do_reset();
    xfer = 3'b001;
    step(w);
    xfer = '0;
    chk("sat_cred", 64'(cred_of(0)), 64'(CB));
    chk("sat_err", 64'(err), 64'd1);
    set_req(0, 1, 48'h7000, 128);
    step(w);
    set_req(0, 0, 48'h0, 0);
    step(w);
    set_req(0, 1, 48'h7080, 128);
    xfer = 3'b001;
    step(w);
    xfer = '0;
    set_req(0, 0, 48'h0, 0);
    chk("net_debit", 64'(cred_of(0)), 64'd29);
    step(w);

    // Reset during ISSUE, then a zero-length read from pointer 0
    do_reset();
    set_req(1, 1, 48'h8000, 640);
    m_req_ready = 1'b0; m_mux_ready = 1'b0;
    step(w);
    set_req(1, 0, 48'h0, 0);
    step(w);
    do_reset();
    for (int d = 0; d < N; d++) set_req(d, 1, 48'(32'h900 + d), 0);
    #1;
    chk("zero_ptr0", 64'(s_req_ready), 64'b001);
    step(w);
    s_req_valid = '0;
    chk("zero_beats", 64'({m_mux_valid, m_mux_beats}), 64'(1 << BW));
    step(w);
    step(w);

    // Random traffic
    do_reset();
    for (int d = 0; d < N; d++) cur_v[d] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int d = 0; d < N; d++) begin
        if (!cur_v[d] && $urandom_range(0, 2) == 0) begin
          automatic int r = $urandom_range(0, 9);
          cur_v[d] = 1;
          cur_a[d] = {16'($urandom), $urandom};
          if (r == 0)      cur_l[d] = $urandom_range(2049, 9000);
          else if (r == 1) cur_l[d] = 0;
          else             cur_l[d] = $urandom_range(1, 2048);
        end
        set_req(d, cur_v[d], cur_a[d], cur_v[d] ? cur_l[d] : 0);
        xfer[d] = (m_cred[d] < CB) && ($urandom_range(0, 1) == 1);
      end
      m_req_ready = ($urandom_range(0, 3) != 0);
      m_mux_ready = ($urandom_range(0, 3) != 0);
      step(w);
      if (w >= 0) cur_v[w] = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/host_rd_cred_sched.md
# host_rd_cred_sched

Credit-based scheduler for host read requests shared by `N_DESTS` destinations.
- Takes one request stream per destination and holds per-destination beat credits that mirror free space in each destination's output data FIFO.
- Grants destinations round-robin, but only when the whole read fits in that destination's credits.
- Issues the winning request to the host read channel, together with a routing descriptor for the read-data mux.
- Sits between the per-destination request queues and the host read request port.

## Interface
Parameters:
- `N_DESTS`, default 4: number of destinations/requesters.
- `CRED_BEATS`, default 32: output FIFO depth per destination, in 64-byte beats.
- `LEN_BITS`, default 28: request length field width, in bytes.
- `VADDR_BITS`, default 48: virtual address width.

Ports (CW = clog2(CRED_BEATS+1), BW = LEN_BITS-6+1, DW = clog2(N_DESTS), minimum 1):
- `aclk`  in  1: single clock.
- `aresetn`  in  1: reset, asynchronous, active-low.
- `s_req_valid`  in  N_DESTS: per-destination request valid.
- `s_req_ready`  out  N_DESTS: per-destination request accept.
- `s_req_vaddr`  in  N_DESTS×VADDR_BITS: request address.
- `s_req_len`  in  N_DESTS×LEN_BITS: request length, bytes.
- `m_req_valid`  out  1: host request valid.
- `m_req_ready`  in  1: host request accept.
- `m_req_vaddr`  out  VADDR_BITS: issued address.
- `m_req_len`  out  LEN_BITS: issued length.
- `m_mux_valid`  out  1: routing descriptor valid.
- `m_mux_ready`  in  1: routing descriptor accept.
- `m_mux_dest`  out  DW: destination of the issued read.
- `m_mux_beats`  out  BW: beats the issued read returns.
- `xfer`  in  N_DESTS: one beat popped from that destination's output FIFO; returns one credit.
- `cred`  out  N_DESTS×CW: current credit count per destination.
- `err`  out  1: sticky error flag.

## Operation
Beat count:
- beats(i) = ceil(s_req_len[i]/64), computed at BW width.
- len=0 gives beats=0. Such a request is eligible regardless of credits and is forwarded with m_mux_beats=0.

Eligibility:
- Destination i is eligible when s_req_valid[i] is high, beats(i) ≤ cred[i], and beats(i) ≤ CRED_BEATS.
- cred[i] is the registered value, before this cycle's xfer.

Oversize requests:
- A valid request with beats > CRED_BEATS can never issue.
- It counts as a grant candidate. When it wins, it is accepted (s_req_ready pulses) and dropped (nothing forwarded), err is set, the state stays IDLE and the pointer advances.

Arbitration:
- Round-robin with a pointer at last grant + 1, modulo N_DESTS.
- The lowest index at or after the pointer wins, wrapping past N_DESTS-1.

State machine:
- IDLE: if any destination is a grant candidate, pulse s_req_ready for the winner only. Capture vaddr, len, dest and beats into the output registers and debit cred[winner] by beats. Go to ISSUE.
- ISSUE: m_req_valid and m_mux_valid start together. Each drops independently after its own handshake. When both are done (including the case where both complete in the same cycle), return to IDLE.
- The outputs of a channel are held stable while its valid is high and its ready is low.

Credit update, every cycle, per destination:
- cred_next = cred + xfer - debit.
- Debit and xfer on the same destination in the same cycle apply together (net change).
- If cred + xfer would exceed CRED_BEATS, cred saturates at CRED_BEATS and err is set.
- Credits never underflow, because debit only happens when beats ≤ cred.

err is cleared only by reset.

## Timing
- Reset values: s_req_ready=0, m_req_valid=0, m_mux_valid=0, m_mux_dest=0, m_mux_beats=0, m_req_vaddr=0, m_req_len=0, cred[i]=CRED_BEATS, err=0, RR pointer=0, state IDLE.
- Reset asserted mid-transfer forces all of the above immediately (asynchronous) and discards any pending request.
- s_req_ready is combinational from the registered state, credits and s_req_valid. It is asserted only in IDLE.
- Latency: a grant in cycle t gives m_req_valid=1 and m_mux_valid=1 in cycle t+1.
- Maximum throughput is one request per 2 cycles: IDLE grant, then ISSUE with same-cycle acceptance on both channels.
- Credits debited in cycle t are visible on cred in t+1. A credit returned by xfer in cycle t enables eligibility from cycle t+1.

## Test plan
- Single destination, CRED_BEATS=32, len=4096 (64 beats): rejected, err=1, no m_req or m_mux issued. Then len=2048: issued, cred 32→0. 32 xfer pulses restore cred to 32.
- Three destinations, all valid with len=64, ready held high: grants in order 0,1,2,0,…, one grant every 2 cycles. m_mux_dest matches each grant and m_mux_beats=1.
- Destination 1 has cred=3 with a pending len=256 (4 beats); destination 2 is valid: destination 2 is granted. After one xfer[1], destination 1 is granted in the next IDLE cycle.
- m_req_ready low for 5 cycles, m_mux_ready high: m_mux completes first, m_req holds stable vaddr and len, and the block returns to IDLE the cycle after m_req is accepted.
- cred[0]=CRED_BEATS and xfer[0]=1: cred stays 32 and err=1. Same-cycle debit of 2 with xfer on destination 0 gives a net -1.
- aresetn dropped during ISSUE: valids low immediately, all credits at 32, pointer 0. After release, a request with len=0 is issued with beats=0.
